id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS core, with the load-use hazard detector built in.
- Captures decoded operands and control from ID and presents the registered rs/rt/rd, data and control fields to EX, including the forwarding logic.
- On a load-use hazard it stalls IF/ID and inserts a bubble. It also services branch flushes and external holds, and keeps saturating stall and flush event counters.

Parameters:
- DATA_W, 32, operand/immediate width
- REG_AW, 5, register address width
- CTRL_W, 8, opaque EX/MEM/WB control bundle width
- CNT_W, 16, event counter width

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- id_valid  input  1  ID holds a real instruction
- id_rs  input  REG_AW  source 1 address
- id_rt  input  REG_AW  source 2 address
- id_rd  input  REG_AW  destination address, already selected by decode
- id_rs_data  input  DATA_W  register file read 1
- id_rt_data  input  DATA_W  register file read 2
- id_imm  input  DATA_W  sign-extended immediate
- id_ctrl  input  CTRL_W  control bundle
- id_reg_write  input  1  instruction writes register file
- id_mem_read  input  1  instruction is a load
- flush  input  1  branch taken in EX; kill the ID instruction
- hold  input  1  downstream not ready; freeze the ID/EX register
- stall  output  1  hold PC and IF/ID this cycle (combinational)
- id_ex_valid  output  1
- id_ex_rs, id_ex_rt, id_ex_rd  output  REG_AW each
- id_ex_rs_data, id_ex_rt_data, id_ex_imm  output  DATA_W each
- id_ex_ctrl  output  CTRL_W
- id_ex_reg_write, id_ex_mem_read  output  1 each
- stall_count  output  CNT_W  load-use bubbles inserted, saturating
- flush_count  output  CNT_W  flush bubbles inserted, saturating

Behaviour:
- Reset (rst=1 at edge):
  - All registered outputs go to 0; both counters go to 0.
  - stall is 0 while rst=1.
- Hazard detect (combinational):
  - lu = id_valid & id_ex_valid & id_ex_mem_read & (id_ex_rd != 0) & ((id_ex_rd == id_rs) | (id_ex_rd == id_rt)).
  - A destination of $0 never hazards.
- stall = ~rst & ~flush & (hold | lu).
- Register update priority per edge, highest first:
  1. rst: clear everything.
  2. flush: load a bubble; if id_valid, flush_count += 1 (saturating).
  3. hold: keep all register contents unchanged; counters unchanged.
  4. lu: load a bubble; stall_count += 1 (saturating).
  5. Otherwise: load all id_* fields, with id_ex_valid <= id_valid.
- Bubble:
  - valid, reg_write, mem_read, ctrl, rs, rt, rd, data and imm are all 0.
  - Zero addresses guarantee the forwarding logic never matches a bubble.
- An input with id_valid=0 is loaded normally. Its reg_write/mem_read are loaded as given; decode drives them to 0 for invalid slots.
- Latency:
  - One cycle from id_* to id_ex_*.
  - A load-use costs exactly one bubble. The cycle after the bubble, lu is false because id_ex_valid=0, so the stalled instruction enters with the load then in EX/MEM.
- Simultaneous events:
  - flush + lu: flush wins, stall=0, one bubble, only flush_count increments.
  - flush + hold: flush wins and the register is bubbled.
  - hold + lu: stall=1, contents held, no count; lu is re-evaluated once hold drops.
- Counters:
  - Saturate at 2^CNT_W-1 with no wrap.
  - Only rst clears them.
- Reset mid-stall: state clears at that edge and stall drops in the same cycle rst is high.

Test Plan:
- Reset, then drive rs=3, rt=4, rd=5, data 0x11/0x22, imm 0x7, ctrl 0xA5, valid -> one edge later the id_ex_* fields equal the inputs; counters are 0.
- Load to rd=8 (mem_read=1), then next instruction rs=8 -> stall=1 for exactly one cycle, a bubble in ID/EX (all zeros), stall_count=1; the following edge loads the rs=8 instruction.
- Load to rd=0, then an instruction with rs=0 -> stall=0, no bubble, stall_count stays 0.
- Load to rd=8 and next rt=8 with flush=1 in the same cycle -> stall=0, bubble, flush_count=1, stall_count=0.
- hold=1 for 3 cycles with changing id_* -> id_ex_* constant, stall=1, counters unchanged; after release, the current id_* loads.
- CNT_W=2, 5 consecutive load-use hazards -> stall_count reads 1, 2, 3, 3, 3; assert rst -> 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with a built-in load-use hazard detector.
// It captures the decoded operands and control from ID and presents them to EX.
// A load-use hazard stalls IF/ID and inserts one bubble. A branch flush kills the
// ID slot, and an external hold freezes the register. Two saturating counters
// record the bubbles inserted for load-use hazards and for flushes.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   id_*              decoded instruction fields from ID
//   flush             branch taken in EX; bubble the ID/EX register
//   hold              downstream not ready; freeze the ID/EX register
//   stall             combinational; hold PC and IF/ID this cycle
//   id_ex_*           registered fields presented to EX
//   stall_count       saturating count of load-use bubbles
//   flush_count       saturating count of flushed valid instructions
module id_ex_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    input  logic              hold,
    output logic              stall,
    output logic              id_ex_valid,
    output logic [REG_AW-1:0] id_ex_rs,
    output logic [REG_AW-1:0] id_ex_rt,
    output logic [REG_AW-1:0] id_ex_rd,
    output logic [DATA_W-1:0] id_ex_rs_data,
    output logic [DATA_W-1:0] id_ex_rt_data,
    output logic [DATA_W-1:0] id_ex_imm,
    output logic [CTRL_W-1:0] id_ex_ctrl,
    output logic              id_ex_reg_write,
    output logic              id_ex_mem_read,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    logic lu;

    // A load in EX whose destination feeds the ID instruction. A $0 destination never hazards.
    always_comb begin
        lu = id_valid & id_ex_valid & id_ex_mem_read & (id_ex_rd != '0) &
             ((id_ex_rd == id_rs) | (id_ex_rd == id_rt));
    end

    // A flush takes priority over both hold and lu, so it never stalls the front end.
    always_comb begin
        stall = ~rst & ~flush & (hold | lu);
    end

    // Pipeline register priority: reset, flush, hold, load-use bubble, normal load.
    always_ff @(posedge clk) begin
        if (rst || flush || (!hold && lu)) begin
            // A bubble is all zeros, so forwarding can never match on it.
            id_ex_valid     <= 1'b0;
            id_ex_rs        <= '0;
            id_ex_rt        <= '0;
            id_ex_rd        <= '0;
            id_ex_rs_data   <= '0;
            id_ex_rt_data   <= '0;
            id_ex_imm       <= '0;
            id_ex_ctrl      <= '0;
            id_ex_reg_write <= 1'b0;
            id_ex_mem_read  <= 1'b0;
        end else if (!hold) begin
            id_ex_valid     <= id_valid;
            id_ex_rs        <= id_rs;
            id_ex_rt        <= id_rt;
            id_ex_rd        <= id_rd;
            id_ex_rs_data   <= id_rs_data;
            id_ex_rt_data   <= id_rt_data;
            id_ex_imm       <= id_imm;
            id_ex_ctrl      <= id_ctrl;
            id_ex_reg_write <= id_reg_write;
            id_ex_mem_read  <= id_mem_read;
        end
    end

    // Saturating event counters; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else if (flush) begin
            if (id_valid && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end else if (!hold && lu) begin
            if (stall_count != '1) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage. It drives directed vectors into two instances, one with
// CNT_W=16 and one with CNT_W=2. A behavioural model predicts every output each
// cycle, and literal checks at key points pin the model.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [7:0]  ctrl;
        logic        rw;
        logic        mr;
    } slot_t;

    logic        clk = 1'b0;
    logic        rst, id_valid, id_reg_write, id_mem_read, flush, hold;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [7:0]  id_ctrl;

    logic        stall, id_ex_valid, id_ex_reg_write, id_ex_mem_read;
    logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd;
    logic [31:0] id_ex_rs_data, id_ex_rt_data, id_ex_imm;
    logic [7:0]  id_ex_ctrl;
    logic [15:0] stall_count, flush_count;

    logic        b_stall, b_valid, b_rw, b_mr;
    logic [4:0]  b_rs, b_rt, b_rd;
    logic [31:0] b_rsd, b_rtd, b_imm;
    logic [7:0]  b_ctrl;
    logic [1:0]  b_sc, b_fc;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    id_ex_stage u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush), .hold(hold),
        .stall(stall), .id_ex_valid(id_ex_valid), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt),
        .id_ex_rd(id_ex_rd), .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data),
        .id_ex_imm(id_ex_imm), .id_ex_ctrl(id_ex_ctrl), .id_ex_reg_write(id_ex_reg_write),
        .id_ex_mem_read(id_ex_mem_read), .stall_count(stall_count), .flush_count(flush_count)
    );

    id_ex_stage #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush), .hold(hold),
        .stall(b_stall), .id_ex_valid(b_valid), .id_ex_rs(b_rs), .id_ex_rt(b_rt),
        .id_ex_rd(b_rd), .id_ex_rs_data(b_rsd), .id_ex_rt_data(b_rtd),
        .id_ex_imm(b_imm), .id_ex_ctrl(b_ctrl), .id_ex_reg_write(b_rw),
        .id_ex_mem_read(b_mr), .stall_count(b_sc), .flush_count(b_fc)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    slot_t m;
    int    m_sc, m_fc, m_sc2, m_fc2;
    bit    m_live = 1'b0;

    function automatic bit model_lu();
        return id_valid && m.valid && m.mr && (m.rd != 0) && (m.rd == id_rs || m.rd == id_rt);
    endfunction

    function automatic int sat_inc(input int v, input int max);
        return (v < max) ? v + 1 : v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m = '0; m_sc = 0; m_fc = 0; m_sc2 = 0; m_fc2 = 0; m_live = 1'b1;
        end else if (flush) begin
            m = '0;
            if (id_valid) begin
                m_fc = sat_inc(m_fc, 65535); m_fc2 = sat_inc(m_fc2, 3);
            end
        end else if (hold) begin
            m = m;
        end else if (model_lu()) begin
            m = '0; m_sc = sat_inc(m_sc, 65535); m_sc2 = sat_inc(m_sc2, 3);
        end else begin
            m = '{id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, id_ctrl,
                  id_reg_write, id_mem_read};
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            logic exp_stall;
            exp_stall = !rst && !flush && (hold || model_lu());
            check("stall", stall, exp_stall);
            check("stall_b", b_stall, exp_stall);
            check("regs", {id_ex_valid, id_ex_rs, id_ex_rt, id_ex_rd, id_ex_rs_data, id_ex_rt_data,
                           id_ex_imm, id_ex_ctrl, id_ex_reg_write, id_ex_mem_read}, m);
            check("regs_b", {b_valid, b_rs, b_rt, b_rd, b_rsd, b_rtd, b_imm, b_ctrl, b_rw, b_mr}, m);
            check("stall_count", stall_count, m_sc);
            check("flush_count", flush_count, m_fc);
            check("stall_count_b", b_sc, m_sc2);
            check("flush_count_b", b_fc, m_fc2);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [31:0] imm, input logic [7:0] ctrl, input logic rw,
                          input logic mr);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd;
        id_imm = imm; id_ctrl = ctrl; id_reg_write = rw; id_mem_read = mr;
    endtask

    int sat_exp [5] = '{1, 2, 3, 3, 3};

    initial begin
        rst = 1'b1; flush = 1'b0; hold = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(); step();
        check("rst_stall", stall, 0);
        check("rst_valid", id_ex_valid, 0);
        check("rst_sc", stall_count, 0);
        check("rst_fc", flush_count, 0);

        // Basic one-cycle capture.
        rst = 1'b0; hold = 1'b0;
        set_in(1, 3, 4, 5, 32'h11, 32'h22, 32'h7, 8'hA5, 1, 0);
        step();
        check("cap_rs", id_ex_rs, 3);
        check("cap_rt", id_ex_rt, 4);
        check("cap_rd", id_ex_rd, 5);
        check("cap_rsd", id_ex_rs_data, 32'h11);
        check("cap_rtd", id_ex_rt_data, 32'h22);
        check("cap_imm", id_ex_imm, 32'h7);
        check("cap_ctrl", id_ex_ctrl, 8'hA5);
        check("cap_valid", id_ex_valid, 1);
        check("cap_sc", stall_count, 0);

        // Load-use on rs: one bubble, then the dependent instruction enters.
        set_in(1, 1, 2, 8, 32'h100, 32'h200, 0, 8'h3C, 1, 1);
        step();
        set_in(1, 8, 9, 10, 32'h33, 32'h44, 0, 8'h01, 1, 0);
        #1 check("lu_stall", stall, 1);
        step();
        check("lu_bub_valid", id_ex_valid, 0);
        check("lu_bub_rd", id_ex_rd, 0);
        check("lu_bub_ctrl", id_ex_ctrl, 0);
        check("lu_sc", stall_count, 1);
        #1 check("lu_stall_drop", stall, 0);
        step();
        check("lu_enter_rs", id_ex_rs, 8);
        check("lu_enter_valid", id_ex_valid, 1);

        // Load to $0 never hazards.
        set_in(1, 1, 2, 0, 0, 0, 0, 0, 1, 1);
        step();
        set_in(1, 0, 0, 3, 0, 0, 0, 0, 1, 0);
        #1 check("r0_stall", stall, 0);
        step();
        check("r0_valid", id_ex_valid, 1);
        check("r0_rd", id_ex_rd, 3);
        check("r0_sc", stall_count, 1);

        // Flush wins over a simultaneous load-use on rt.
        set_in(1, 1, 2, 8, 0, 0, 0, 0, 1, 1);
        step();
        set_in(1, 9, 8, 3, 0, 0, 0, 0, 1, 0);
        flush = 1'b1;
        #1 check("fl_stall", stall, 0);
        step();
        check("fl_valid", id_ex_valid, 0);
        check("fl_fc", flush_count, 1);
        check("fl_sc", stall_count, 1);

        // Flushing an invalid slot bubbles but does not count.
        set_in(0, 4, 5, 6, 0, 0, 0, 0, 0, 0);
        step();
        check("fl_inv_fc", flush_count, 1);
        flush = 1'b0;

        // Hold freezes contents for three cycles while ID keeps changing.
        set_in(1, 6, 7, 11, 32'h66, 32'h77, 32'h5, 8'h5A, 1, 0);
        step();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1, 5'(12 + i), 5'(13 + i), 5'(14 + i), 32'(i), 32'(i), 32'(i), 8'(i), 0, 0);
            #1 check("hold_stall", stall, 1);
            step();
            check("hold_rs", id_ex_rs, 6);
            check("hold_rsd", id_ex_rs_data, 32'h66);
        end
        hold = 1'b0;
        set_in(1, 20, 21, 22, 32'h99, 32'h98, 32'h97, 8'h96, 1, 0);
        step();
        check("rel_rs", id_ex_rs, 20);
        check("rel_imm", id_ex_imm, 32'h97);

        // Hold plus load-use: held without counting, bubble once hold drops.
        set_in(1, 1, 2, 8, 0, 0, 0, 0, 1, 1);
        step();
        set_in(1, 8, 0, 4, 0, 0, 0, 0, 1, 0);
        hold = 1'b1;
        #1 check("hlu_stall", stall, 1);
        step();
        check("hlu_rd_held", id_ex_rd, 8);
        check("hlu_sc", stall_count, 1);
        hold = 1'b0;
        #1 check("hlu_stall2", stall, 1);
        step();
        check("hlu_bub", id_ex_valid, 0);
        check("hlu_sc2", stall_count, 2);
        step();
        check("hlu_enter", id_ex_rs, 8);

        // Reset mid-stall drops stall in the same cycle.
        set_in(1, 1, 2, 8, 0, 0, 0, 0, 1, 1);
        step();
        set_in(1, 8, 0, 4, 0, 0, 0, 0, 1, 0);
        #1 check("rms_stall", stall, 1);
        rst = 1'b1;
        #1 check("rms_stall_rst", stall, 0);
        step();
        check("rms_valid", id_ex_valid, 0);
        check("rms_sc", stall_count, 0);
        check("rms_fc", flush_count, 0);
        rst = 1'b0;

        // Back-to-back self-dependent loads saturate the 2-bit counter.
        set_in(1, 8, 8, 8, 32'h5, 32'h6, 0, 8'h11, 1, 1);
        step();
        for (int k = 0; k < 5; k++) begin
            step();
            check("sat_b_sc", b_sc, sat_exp[k]);
            check("sat_sc", stall_count, k + 1);
            step();
        end
        rst = 1'b1;
        step();
        check("sat_rst", b_sc, 0);
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(); step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
